// File: rtl/fetch_sched_pkg.sv
// Shared types for the line-fetch scheduler: command encoding, port owner, FSM state.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fetch_sched_pkg;

    typedef enum logic [1:0] {
        FETCH_NOP   = 2'b00,
        FETCH_RD    = 2'b01,
        FETCH_WB_RD = 2'b10
    } fetch_cmd_t;

    typedef enum logic {
        OWN_W = 1'b0,
        OWN_R = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } sched_state_t;

    // Only 01 and 10 go downstream; 00 and the unused 11 complete locally.
    function automatic logic cmd_is_fetch(input logic [1:0] cmd);
        return (cmd == FETCH_RD) || (cmd == FETCH_WB_RD);
    endfunction

endpackage

// File: rtl/fetch_sched_if.sv
// Bundle of the two miss-port handshakes plus the fetch-controller handshake.
// Latency: n/a (wires only).
// Backpressure: port side via gnt_x (queue not full), fetch side via fetch_gnt.
// master = cache miss logic + fetch controller side; slave = the scheduler.
interface fetch_sched_if #(
    parameter int AW = 32,
    parameter int TW = 2
);
    // write-side miss port
    logic          req_w;
    logic          gnt_w;
    logic [1:0]    cmd_w;
    logic [TW-1:0] tag_w;
    logic [AW-1:0] addr_w;
    logic [AW-1:0] addr_pre_w;
    logic          done_w;
    // read-side miss port
    logic          req_r;
    logic          gnt_r;
    logic [1:0]    cmd_r;
    logic [TW-1:0] tag_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_pre_r;
    logic          done_r;
    // fetch controller port
    logic          fetch_req;
    logic          fetch_gnt;
    logic [1:0]    fetch_cmd;
    logic [TW-1:0] fetch_tag;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] fetch_addr_pre;
    logic          fetch_done;
    // status
    logic          busy;
    logic          err_timeout;

    modport master (
        output req_w, cmd_w, tag_w, addr_w, addr_pre_w,
        input  gnt_w, done_w,
        output req_r, cmd_r, tag_r, addr_r, addr_pre_r,
        input  gnt_r, done_r,
        input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
        output fetch_gnt, fetch_done,
        input  busy, err_timeout
    );

    modport slave (
        input  req_w, cmd_w, tag_w, addr_w, addr_pre_w,
        output gnt_w, done_w,
        input  req_r, cmd_r, tag_r, addr_r, addr_pre_r,
        output gnt_r, done_r,
        output fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
        input  fetch_gnt, fetch_done,
        output busy, err_timeout
    );

endinterface

// File: rtl/fetch_sched_req_fifo.sv
// Per-port request queue: small synchronous FIFO with wrap-bit pointers.
// Latency: a push is visible at head the cycle after the push edge.
// Backpressure: full when depth entries held; push ignored while full, pop ignored while empty.
// Ports: clk, rst_n, push/din, pop, full, empty, head (entry at read pointer).
module fetch_req_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);
    localparam int PW = $clog2(depth);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic [width-1:0] mem_q [depth];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the write pointer lapped the read pointer.
    assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign head    = mem_q[rptr_q[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: head is only consumed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/fetch_sched.sv
// Shares one line-fetch controller between write- and read-side miss ports, round-robin, one fetch in flight.
// Latency: push->fetch_req 2 cycles from idle; fetch_done->done_x 1 cycle; NOP push->done_x 2 cycles.
// Backpressure: gnt_x low while that port queue is full; fetch fields held until fetch_gnt.
// Ports: clk, rst_n, bus (slave): req/gnt/cmd/tag/addr/addr_pre/done per port, fetch_* to controller,
//        busy (not idle), err_timeout (sticky watchdog expiry).
module fetch_sched #(
    parameter int addr_width  = 32,
    parameter int list_depth  = 4,
    parameter int q_depth     = 2,
    parameter int timeout_cyc = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_sched_if.slave bus
);
    import fetch_sched_pkg::*;

    localparam int TW  = $clog2(list_depth);
    localparam int WDW = $clog2(timeout_cyc) + 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(timeout_cyc - 1);
    localparam logic [WDW-1:0] WDOG_ONE  = WDW'(1);
    localparam logic [WDW-1:0] WDOG_MAX  = '1;

    typedef struct packed {
        logic [1:0]            cmd;
        logic [TW-1:0]         tag;
        logic [addr_width-1:0] addr;
        logic [addr_width-1:0] addr_pre;
    } fetch_entry_t;

    localparam int EW = $bits(fetch_entry_t);

    sched_state_t state_q, state_d;
    owner_t       owner_q, owner_d;
    owner_t       rr_last_q, rr_last_d;
    fetch_entry_t lat_q, lat_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic         err_q, err_d;

    fetch_entry_t din_w, din_r, head_w, head_r, sel_ent;
    owner_t       sel;
    logic         full_w, full_r, empty_w, empty_r;
    logic         pop_w, pop_r;
    logic         fetch_req_c, done_w_c, done_r_c;

    assign din_w = '{cmd: bus.cmd_w, tag: bus.tag_w, addr: bus.addr_w, addr_pre: bus.addr_pre_w};
    assign din_r = '{cmd: bus.cmd_r, tag: bus.tag_r, addr: bus.addr_r, addr_pre: bus.addr_pre_r};

    fetch_req_fifo #(.width(EW), .depth(q_depth)) u_q_w (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_w),
        .din   (din_w),
        .pop   (pop_w),
        .full  (full_w),
        .empty (empty_w),
        .head  (head_w)
    );

    fetch_req_fifo #(.width(EW), .depth(q_depth)) u_q_r (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_r),
        .din   (din_r),
        .pop   (pop_r),
        .full  (full_r),
        .empty (empty_r),
        .head  (head_r)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        lat_d       = lat_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        pop_w       = 1'b0;
        pop_r       = 1'b0;
        fetch_req_c = 1'b0;
        done_w_c    = 1'b0;
        done_r_c    = 1'b0;
        sel         = OWN_W;
        sel_ent     = head_w;

        unique case (state_q)
            S_IDLE: begin
                if (!empty_w || !empty_r) begin
                    if (empty_w)      sel = OWN_R;
                    else if (empty_r) sel = OWN_W;
                    else              sel = (rr_last_q == OWN_W) ? OWN_R : OWN_W;
                    sel_ent = (sel == OWN_R) ? head_r : head_w;
                    lat_d   = sel_ent;
                    owner_d = sel;
                    if (cmd_is_fetch(sel_ent.cmd)) begin
                        // Entry stays queued until the controller accepts it.
                        state_d = S_ISSUE;
                    end else begin
                        pop_w   = (sel == OWN_W);
                        pop_r   = (sel == OWN_R);
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                fetch_req_c = 1'b1;
                if (bus.fetch_gnt) begin
                    pop_w   = (owner_q == OWN_W);
                    pop_r   = (owner_q == OWN_R);
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wdog_q != WDOG_MAX) wdog_d = wdog_q + WDOG_ONE;
                if (bus.fetch_done) begin
                    state_d = S_DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    // Force completion so the port is never stuck; any later done is dropped in S_IDLE.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_w_c  = (owner_q == OWN_W);
                done_r_c  = (owner_q == OWN_R);
                rr_last_d = owner_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_W;
            rr_last_q <= OWN_R;
            lat_q     <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            lat_q     <= lat_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt_w          = !full_w;
    assign bus.gnt_r          = !full_r;
    assign bus.done_w         = done_w_c;
    assign bus.done_r         = done_r_c;
    assign bus.fetch_req      = fetch_req_c;
    assign bus.fetch_cmd      = lat_q.cmd;
    assign bus.fetch_tag      = lat_q.tag;
    assign bus.fetch_addr     = lat_q.addr;
    assign bus.fetch_addr_pre = lat_q.addr_pre;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_fetch_sched.sv
`timescale 1ns/1ps
module tb_fetch_sched;
    import fetch_sched_pkg::*;

    localparam int AW = 32;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sched_if #(.AW(AW), .TW(TW)) bus ();

    fetch_sched #(
        .addr_width  (AW),
        .list_depth  (4),
        .q_depth     (2),
        .timeout_cyc (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        owner_t        own;
        logic [1:0]    cmd;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [AW-1:0] addr_pre;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input owner_t o, input logic [1:0] c, input logic [TW-1:0] t,
                                input logic [AW-1:0] a, input logic [AW-1:0] p);
        exp_t x;
        x.own = o; x.cmd = c; x.tag = t; x.addr = a; x.addr_pre = p;
        return x;
    endfunction

    task automatic drive(input exp_t x, input logic v);
        if (x.own == OWN_W) begin
            bus.req_w = v; bus.cmd_w = x.cmd; bus.tag_w = x.tag;
            bus.addr_w = x.addr; bus.addr_pre_w = x.addr_pre;
        end else begin
            bus.req_r = v; bus.cmd_r = x.cmd; bus.tag_r = x.tag;
            bus.addr_r = x.addr; bus.addr_pre_r = x.addr_pre;
        end
    endtask

    // One-cycle request; returns at the negedge following the push edge.
    task automatic send(input string tag, input exp_t x);
        @(negedge clk);
        drive(x, 1'b1);
        chk({tag, "_gnt"}, 64'((x.own == OWN_W) ? bus.gnt_w : bus.gnt_r), 64'd1);
        if (x.cmd == 2'b01 || x.cmd == 2'b10) sb.push_back(x);
        @(negedge clk);
        drive(x, 1'b0);
    endtask

    // Bounded wait for fetch_req, then compare the presented fields with the scoreboard head.
    task automatic wait_issue(input string tag);
        int n = 0;
        exp_t x;
        while (bus.fetch_req !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_issue"}, 64'(bus.fetch_req), 64'd0);
        end else begin
            x = sb[0];
            chk({tag, "_req"}, 64'(bus.fetch_req), 64'd1);
            chk({tag, "_cmd_tag"}, 64'({bus.fetch_cmd, bus.fetch_tag}), 64'({x.cmd, x.tag}));
            chk({tag, "_addr"}, 64'(bus.fetch_addr), 64'(x.addr));
            chk({tag, "_pre"}, 64'(bus.fetch_addr_pre), 64'(x.addr_pre));
        end
    endtask

    task automatic grant_one(input string tag);
        bus.fetch_gnt = 1'b1;
        @(negedge clk);
        bus.fetch_gnt = 1'b0;
        chk({tag, "_in_wait"}, 64'({bus.busy, bus.fetch_req}), 64'b10);
    endtask

    task automatic finish_fetch(input string tag, input int delay);
        exp_t x;
        repeat (delay) @(negedge clk);
        chk({tag, "_quiet"}, 64'({bus.done_w, bus.done_r}), 64'd0);
        bus.fetch_done = 1'b1;
        @(negedge clk);
        bus.fetch_done = 1'b0;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_done"}, 64'({bus.done_w, bus.done_r}), 64'({x.own == OWN_W, x.own == OWN_R}));
        end
    endtask

    initial begin
        exp_t e, w0, w1, r0, r1, e2;
        logic flag;
        logic err_pre;

        bus.req_w = 0; bus.cmd_w = 0; bus.tag_w = 0; bus.addr_w = 0; bus.addr_pre_w = 0;
        bus.req_r = 0; bus.cmd_r = 0; bus.tag_r = 0; bus.addr_r = 0; bus.addr_pre_r = 0;
        bus.fetch_gnt = 0; bus.fetch_done = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'({bus.gnt_w, bus.gnt_r}), 64'd3);
        chk("rst_ctl", 64'({bus.done_w, bus.done_r, bus.fetch_req, bus.busy, bus.err_timeout}), 64'd0);
        chk("rst_fields", 64'({bus.fetch_cmd, bus.fetch_tag, bus.fetch_addr}), 64'd0);
        rst_n = 1'b1;

        // 1: single W read, exact issue latency, done routed to W only
        send("t1", mk(OWN_W, 2'b01, 2'd2, 32'h1040, 32'h2040));
        chk("t1_req_early", 64'(bus.fetch_req), 64'd0);
        @(negedge clk);
        chk("t1_req_lat", 64'(bus.fetch_req), 64'd1);
        wait_issue("t1");
        grant_one("t1");
        finish_fetch("t1", 10);

        // 3: local NOP completion (11 on W, then 00 on R with a stray fetch_gnt)
        send("t3w", mk(OWN_W, 2'b11, 2'd1, 32'h7000, 32'h0));
        chk("t3w_pre", 64'({bus.done_w, bus.fetch_req}), 64'd0);
        @(negedge clk);
        chk("t3w_done", 64'({bus.done_w, bus.done_r, bus.fetch_req}), 64'b100);
        bus.fetch_gnt = 1'b1;
        send("t3r", mk(OWN_R, 2'b00, 2'd3, 32'h7100, 32'h0));
        chk("t3r_pre", 64'({bus.done_r, bus.fetch_req}), 64'd0);
        @(negedge clk);
        chk("t3r_done", 64'({bus.done_w, bus.done_r, bus.fetch_req}), 64'b010);
        bus.fetch_gnt = 1'b0;
        @(negedge clk);
        chk("t3_idle", 64'({bus.busy, bus.fetch_req, bus.done_r}), 64'd0);

        // 2: simultaneous requests alternate W,R,W,R
        for (int rnd = 0; rnd < 2; rnd++) begin
            w0 = mk(OWN_W, 2'b01, 2'd0, 32'h3000 + 32'(rnd * 16),     32'h8000);
            r0 = mk(OWN_R, 2'b01, 2'd1, 32'h3000 + 32'(rnd * 16 + 1), 32'h8001);
            w1 = mk(OWN_W, 2'b10, 2'd2, 32'h3000 + 32'(rnd * 16 + 2), 32'h8002);
            r1 = mk(OWN_R, 2'b01, 2'd3, 32'h3000 + 32'(rnd * 16 + 3), 32'h8003);
            @(negedge clk);
            drive(w0, 1'b1); drive(r0, 1'b1);
            chk("t2_gnt0", 64'({bus.gnt_w, bus.gnt_r}), 64'd3);
            @(negedge clk);
            drive(w1, 1'b1); drive(r1, 1'b1);
            chk("t2_gnt1", 64'({bus.gnt_w, bus.gnt_r}), 64'd3);
            @(negedge clk);
            drive(w1, 1'b0); drive(r1, 1'b0);
            chk("t2_full", 64'({bus.gnt_w, bus.gnt_r}), 64'd0);
            sb.push_back(w0); sb.push_back(r0); sb.push_back(w1); sb.push_back(r1);
            for (int k = 0; k < 4; k++) begin
                wait_issue("t2");
                grant_one("t2");
                finish_fetch("t2", 3);
            end
        end

        // 4: fill W queue while the controller stalls; held request is not lost
        send("t4a", mk(OWN_W, 2'b01, 2'd0, 32'h4000, 32'h9000));
        send("t4b", mk(OWN_W, 2'b01, 2'd1, 32'h4040, 32'h9040));
        e2 = mk(OWN_W, 2'b10, 2'd2, 32'h4080, 32'h9080);
        @(negedge clk);
        drive(e2, 1'b1);
        chk("t4_full", 64'(bus.gnt_w), 64'd0);
        repeat (3) @(negedge clk);
        chk("t4_held", 64'(bus.gnt_w), 64'd0);
        wait_issue("t4a");
        grant_one("t4a");
        chk("t4_reopen", 64'(bus.gnt_w), 64'd1);
        sb.push_back(e2);
        @(negedge clk);
        drive(e2, 1'b0);
        chk("t4_refull", 64'(bus.gnt_w), 64'd0);
        finish_fetch("t4a", 2);
        wait_issue("t4b");
        grant_one("t4b");
        finish_fetch("t4b", 2);
        wait_issue("t4c");
        grant_one("t4c");
        finish_fetch("t4c", 2);

        // 5: watchdog expiry 17 cycles after the grant cycle, late done ignored
        send("t5", mk(OWN_W, 2'b10, 2'd3, 32'h5000, 32'h6000));
        wait_issue("t5");
        bus.fetch_gnt = 1'b1;
        flag = 1'b0;
        err_pre = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) bus.fetch_gnt = 1'b0;
            flag = flag | bus.done_w | bus.done_r;
            if (k == 16) err_pre = bus.err_timeout;
        end
        chk("t5_no_early_done", 64'(flag), 64'd0);
        chk("t5_err_pre", 64'(err_pre), 64'd0);
        @(negedge clk);
        chk("t5_timeout_done", 64'({bus.done_w, bus.done_r}), 64'b10);
        chk("t5_err", 64'(bus.err_timeout), 64'd1);
        if (sb.size() > 0) e = sb.pop_front();
        @(negedge clk);
        bus.fetch_done = 1'b1;
        @(negedge clk);
        bus.fetch_done = 1'b0;
        chk("t5_late_ignored", 64'({bus.done_w, bus.done_r, bus.busy}), 64'd0);
        chk("t5_err_sticky", 64'(bus.err_timeout), 64'd1);
        send("t5n", mk(OWN_R, 2'b01, 2'd1, 32'h5100, 32'h6100));
        wait_issue("t5n");
        grant_one("t5n");
        finish_fetch("t5n", 4);

        // 6: reset in the middle of S_WAIT
        send("t6", mk(OWN_W, 2'b01, 2'd2, 32'h6200, 32'h6300));
        wait_issue("t6");
        grant_one("t6");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'({bus.busy, bus.fetch_req, bus.err_timeout}), 64'd0);
        chk("t6_rst_gnt", 64'({bus.gnt_w, bus.gnt_r}), 64'd3);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.fetch_done = (k == 1);
            flag = flag | bus.done_w | bus.done_r | bus.busy;
        end
        bus.fetch_done = 1'b0;
        chk("t6_no_done", 64'(flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
